// File: rtl/nd_nto1_rr.sv
// nd_nto1_rr: NCH-input to 1-output message merger with a shared FIFO.
// Inputs are arbitrated by round-robin (RR_MODE=1) or by fixed priority
// with the lowest index winning (RR_MODE=0). Accepted messages are queued
// in order and then presented one at a time on the snd0_* channel. All
// channels use a 4-phase req/ack handshake.
module nd_nto1_rr #(
    parameter int NCH     = 4,
    parameter int FSZ     = 4,
    parameter int ASZ     = 6,
    parameter int DSZ     = 16,
    parameter int RSZ     = 4,
    parameter int RR_MODE = 1
) (
    input  logic                   gch_clk,
    input  logic                   gch_reset,
    output logic                   gch_ready,
    input  logic [NCH-1:0]         rcv_req,
    output logic [NCH-1:0]         rcv_ack,
    input  logic [NCH*ASZ-1:0]     rcv_src,
    input  logic [NCH*ASZ-1:0]     rcv_dst,
    input  logic [NCH*DSZ-1:0]     rcv_dat,
    input  logic [NCH*RSZ-1:0]     rcv_red,
    output logic                   snd0_req,
    input  logic                   snd0_ack,
    output logic [ASZ-1:0]         snd0_src,
    output logic [ASZ-1:0]         snd0_dst,
    output logic [DSZ-1:0]         snd0_dat,
    output logic [RSZ-1:0]         snd0_red,
    output logic [$clog2(FSZ):0]   fifo_cnt
);

    localparam int PW = $clog2(FSZ);
    localparam int CW = PW + 1;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MW = 2 * ASZ + DSZ + RSZ;

    // (a + b) mod NCH for operands already below NCH; works for any NCH.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
        logic [IW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (IW+1)'(NCH))
            s = s - (IW+1)'(NCH);
        return s[IW-1:0];
    endfunction

    logic              ready_q;
    logic [NCH-1:0]    ack_q, ack_d;
    logic [IW-1:0]     rr_ptr_q;
    logic [PW-1:0]     head_q, tail_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              snd_req_q, busy_q;
    logic [ASZ-1:0]    snd_src_q, snd_dst_q;
    logic [DSZ-1:0]    snd_dat_q;
    logic [RSZ-1:0]    snd_red_q;
    logic [MW-1:0]     mem_q [FSZ];

    logic [NCH-1:0]    pend;
    logic [NCH-1:0]    rot;
    logic [IW-1:0]     rot_base;
    logic [IW-1:0]     enc;
    logic              win_vld;
    logic [IW-1:0]     win_idx;
    logic [MW-1:0]     ch_msg [NCH];
    logic [MW-1:0]     msg_in;
    logic              push, pop;

    // A channel is pending until its ack is raised; an acked channel must drop req first.
    assign pend     = rcv_req & ~ack_q;
    // Fixed-priority mode always scans from index 0.
    assign rot_base = (RR_MODE != 0) ? rr_ptr_q : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            // rot[k] is the pending flag of the channel k places after the scan start.
            assign rot[gi]    = pend[wrap_add(rot_base, IW'(gi))];
            assign ch_msg[gi] = {rcv_src[gi*ASZ +: ASZ], rcv_dst[gi*ASZ +: ASZ],
                                 rcv_dat[gi*DSZ +: DSZ], rcv_red[gi*RSZ +: RSZ]};
            // Set on the accept of this channel, cleared once its request drops.
            assign ack_d[gi]  = ack_q[gi] ? rcv_req[gi] : (push && (win_idx == IW'(gi)));
        end
    endgenerate

    // Lowest set bit of the rotated pending vector is the first pending channel in scan order.
    always_comb begin
        enc     = '0;
        win_vld = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                enc     = IW'(k);
                win_vld = 1'b1;
            end
        end
    end

    assign win_idx = wrap_add(rot_base, enc);
    assign msg_in  = ch_msg[win_idx];

    // Occupancy is sampled at the start of the cycle, so a pop never frees space for a same-cycle push.
    assign push = ready_q && win_vld && (cnt_q != CW'(FSZ));
    assign pop  = ready_q && !busy_q && (cnt_q != '0);

    // Occupancy next-state: push and pop together leave the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (!push && pop)
            cnt_d = cnt_q - CW'(1);
    end

    // FIFO storage: write-only here, read registered into the output stage.
    always_ff @(posedge gch_clk) begin
        if (push)
            mem_q[tail_q] <= msg_in;
    end

    // Readiness, input acks, arbitration pointer and FIFO pointers.
    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            ready_q  <= 1'b0;
            ack_q    <= '0;
            rr_ptr_q <= '0;
            tail_q   <= '0;
            head_q   <= '0;
            cnt_q    <= '0;
        end else begin
            ready_q <= 1'b1;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
            if (push) begin
                tail_q <= tail_q + PW'(1);
                if (RR_MODE != 0)
                    rr_ptr_q <= wrap_add(win_idx, IW'(1));
            end
            if (pop)
                head_q <= head_q + PW'(1);
        end
    end

    // Output stage: load the head message, then run the 4-phase handshake before the next load.
    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            snd_req_q <= 1'b0;
            busy_q    <= 1'b0;
            snd_src_q <= '0;
            snd_dst_q <= '0;
            snd_dat_q <= '0;
            snd_red_q <= '0;
        end else if (pop) begin
            {snd_src_q, snd_dst_q, snd_dat_q, snd_red_q} <= mem_q[head_q];
            snd_req_q <= 1'b1;
            busy_q    <= 1'b1;
        end else begin
            if (snd_req_q && snd0_ack)
                snd_req_q <= 1'b0;
            if (!snd_req_q && !snd0_ack && busy_q)
                busy_q <= 1'b0;
        end
    end

    assign gch_ready = ready_q;
    assign rcv_ack   = ack_q;
    assign snd0_req  = snd_req_q;
    assign snd0_src  = snd_src_q;
    assign snd0_dst  = snd_dst_q;
    assign snd0_dat  = snd_dat_q;
    assign snd0_red  = snd_red_q;
    assign fifo_cnt  = cnt_q;

endmodule
